posit_mult_pipe: RTL
====================

Name: posit_mult_pipe

Overview:
- Multi-lane, two-stage pipelined posit multiply core. Consumes decoded posit fields (sign, regime, exponent, fraction, zero/NaR flags) for LANES independent operand pairs.
- Produces per lane: product sign, combined signed scale, full-width significand product and special-value flags.
- Sits between the posit decoder and the normaliser/rounder in the PE datapath.
- Adds a valid/ready handshake with full-throughput backpressure, explicit zero/NaR handling and optional post-multiply normalisation.

Parameters:
- WIDTH, 8, posit word width.
- EXP, 2, exponent field width (es).
- LANES, 1, number of independent multiply lanes sharing one handshake.
- REGI, $clog2(WIDTH)+1, signed regime field width (derived).
- MTS, WIDTH-3-EXP, stored fraction width, hidden bit excluded (derived).
- SCW, REGI+EXP+2, signed product scale width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  stage 1 can accept.
- sign_a, sign_b  in  LANES  operand signs, lane i = bit i.
- regi_a, regi_b  in  LANES*REGI  signed regime k, lane i = [i*REGI +: REGI].
- exp_a, exp_b  in  LANES*EXP  exponent fields.
- mts_a, mts_b  in  LANES*MTS  fraction fields, hidden bit excluded.
- zero_a, zero_b  in  LANES  operand is zero.
- nar_a, nar_b  in  LANES  operand is NaR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- sign_m  out  LANES  product sign.
- scale_m  out  LANES*SCW  signed product scale.
- mts_m  out  LANES*2*(MTS+1)  significand product, format xx.f (two integer bits).
- zero_m, nar_m  out  LANES  result flags.

Behaviour:
- Reset: s1_valid, s2_valid, out_valid = 0; all stage registers and outputs = 0.
- Handshake:
  - Transfer on valid & ready.
  - s2_ready = ~s2_valid | out_ready; s1_ready = ~s1_valid | s2_ready; in_ready = s1_ready.
  - Full throughput of one set per cycle when out_ready is held high.
  - Latency: 2 cycles from input transfer to out_valid with no stall.
- Stage 1 (register on input transfer), per lane:
  - scale = (regi_a<<<EXP) + exp_a + (regi_b<<<EXP) + exp_b, all sign-extended to SCW.
  - sign = sign_a ^ sign_b.
  - Isolated significands {1,mts} are registered; they are forced to 0 when the lane is zero or NaR.
- Stage 2 (register on s1→s2 transfer): mts_m = sigA * sigB (unsigned, 2*(MTS+1) bits, range 01.x to 11.x); remaining fields pass through.
- Special values, per lane:
  - nar_m = nar_a | nar_b.
  - zero_m = (zero_a | zero_b) & ~nar_m.
  - When zero_m or nar_m is set: sign_m = 0, scale_m = 0, mts_m = 0.
- Lanes are fully independent; a special value in one lane does not affect the others.
- Stall: while out_valid & ~out_ready, the outputs hold stable. Stage 1 holds if stage 2 is full. in_ready drops only when both stages are full.
- Simultaneous push and pop on a full pipe: both transfers occur in the same cycle and no bubble is inserted.
- Reset mid-operation: in-flight data is discarded; out_valid = 0 on the first edge after rstn rises.
- Outputs are registered; there is no combinational path from in_* to out_*. out_ready reaches in_ready combinationally through the ready chain only.

Optional Feature:
- Macro: POSIT_MULT_NORM_EN.
- Defined: stage 2 normalises each product.
  - If the product MSB = 1: mts_m = product >> 1 with the lost LSB ORed into the new LSB (sticky), and scale_m = scale + 1.
  - Otherwise the product and scale are unchanged.
  - The output is then always 01.f, or 0 for special lanes.
- Undefined: the raw product is output and scale_m is unadjusted. Latency is identical in both builds.

Test Plan:
All scenarios use WIDTH=8, EXP=2, MTS=3, SCW=8.
1. Lane 1.0*1.0: regi=0, exp=0, mts=000 on both operands → after 2 cycles mts_m=0x40, scale_m=0, sign_m=0, flags 0.
2. Lane 1.5*(-1.5): mts=100, sign_b=1 → mts_m=0x90, scale_m=0, sign_m=1; with POSIT_MULT_NORM_EN: mts_m=0x48, scale_m=1.
3. Scale arithmetic:
   - regi_a=2, exp_a=3, regi_b=-3, exp_b=1 → scale_m=0.
   - regi_a=6, exp_a=3, regi_b=6, exp_b=3 → scale_m=54.
   - regi_a=-7, exp_a=0 on both → scale_m=-56.
4. Specials with LANES=2:
   - Lane0 nar_a=1 and lane1 zero_b=1 → nar_m=01, zero_m=10, and lane 0 and lane 1 fields all 0.
   - NaR*zero → nar_m=1, zero_m=0.
5. Backpressure: stream 6 sets with out_ready low for cycles 3-6 → in_ready=0 after 2 accepted sets, outputs held stable, all 6 results emerge in order with no loss or duplication.
6. Assert rstn low while 2 sets are in flight → out_valid=0 and outputs 0 immediately; after release the next input appears 2 cycles after transfer.

Source files
------------

// File: rtl/posit_mult_pipe.sv
// posit_mult_pipe: two-stage multi-lane posit multiply core (sign, scale, significand product, zero/NaR flags).
// Define POSIT_MULT_NORM_EN to normalise each product to 01.f in stage 2.
module posit_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int EXP   = 2,
    parameter int LANES = 1,
    parameter int REGI  = $clog2(WIDTH) + 1,
    parameter int MTS   = WIDTH - 3 - EXP,
    parameter int SCW   = REGI + EXP + 2
) (
    input  logic                      clk_i,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          sign_a,
    input  logic [LANES-1:0]          sign_b,
    input  logic [LANES*REGI-1:0]     regi_a,
    input  logic [LANES*REGI-1:0]     regi_b,
    input  logic [LANES*EXP-1:0]      exp_a,
    input  logic [LANES*EXP-1:0]      exp_b,
    input  logic [LANES*MTS-1:0]      mts_a,
    input  logic [LANES*MTS-1:0]      mts_b,
    input  logic [LANES-1:0]          zero_a,
    input  logic [LANES-1:0]          zero_b,
    input  logic [LANES-1:0]          nar_a,
    input  logic [LANES-1:0]          nar_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          sign_m,
    output logic [LANES*SCW-1:0]      scale_m,
    output logic [LANES*2*(MTS+1)-1:0] mts_m,
    output logic [LANES-1:0]          zero_m,
    output logic [LANES-1:0]          nar_m
);
    localparam int SW = MTS + 1;
    localparam int PW = 2 * SW;

    logic                 s1_valid, s2_valid, s1_ready, s2_ready;
    logic [LANES-1:0]     sp, n1_sign, n1_zero, n1_nar, s1_sign, s1_zero, s1_nar;
    logic [LANES*SCW-1:0] n1_scale, s1_scale, n2_scale;
    logic [LANES*SW-1:0]  n1_siga, n1_sigb, s1_siga, s1_sigb;
    logic [LANES*PW-1:0]  n2_mts;
    logic [PW-1:0]        prod [LANES];

    assign s2_ready  = ~s2_valid | out_ready;
    assign s1_ready  = ~s1_valid | s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;

    // Special lanes are zeroed at stage 1 so the multiplier sees 0 and nothing leaks to the outputs
    assign sp      = nar_a | nar_b | zero_a | zero_b;
    assign n1_nar  = nar_a | nar_b;
    assign n1_zero = (zero_a | zero_b) & ~n1_nar;
    assign n1_sign = (sign_a ^ sign_b) & ~sp;

    always_comb begin
        n1_scale = '0;
        n1_siga  = '0;
        n1_sigb  = '0;
        for (int l = 0; l < LANES; l++) begin
            n1_scale[l*SCW +: SCW] = sp[l] ? '0 :
                (SCW'($signed(regi_a[l*REGI +: REGI])) << EXP) + SCW'(exp_a[l*EXP +: EXP]) +
                (SCW'($signed(regi_b[l*REGI +: REGI])) << EXP) + SCW'(exp_b[l*EXP +: EXP]);
            n1_siga[l*SW +: SW] = sp[l] ? '0 : {1'b1, mts_a[l*MTS +: MTS]};
            n1_sigb[l*SW +: SW] = sp[l] ? '0 : {1'b1, mts_b[l*MTS +: MTS]};
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            prod[l] = PW'(s1_siga[l*SW +: SW]) * PW'(s1_sigb[l*SW +: SW]);
    end

    always_comb begin
        n2_mts   = '0;
        n2_scale = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef POSIT_MULT_NORM_EN
            n2_mts[l*PW +: PW]     = prod[l][PW-1] ? {1'b0, prod[l][PW-1:2], |prod[l][1:0]} : prod[l];
            n2_scale[l*SCW +: SCW] = s1_scale[l*SCW +: SCW] + SCW'(prod[l][PW-1]);
`else
            n2_mts[l*PW +: PW]     = prod[l];
            n2_scale[l*SCW +: SCW] = s1_scale[l*SCW +: SCW];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_sign  <= '0;
            s1_zero  <= '0;
            s1_nar   <= '0;
            s1_scale <= '0;
            s1_siga  <= '0;
            s1_sigb  <= '0;
            sign_m   <= '0;
            scale_m  <= '0;
            mts_m    <= '0;
            zero_m   <= '0;
            nar_m    <= '0;
        end else begin
            if (s1_ready) s1_valid <= in_valid;
            if (s2_ready) s2_valid <= s1_valid;
            if (in_valid & s1_ready) begin
                s1_sign  <= n1_sign;
                s1_zero  <= n1_zero;
                s1_nar   <= n1_nar;
                s1_scale <= n1_scale;
                s1_siga  <= n1_siga;
                s1_sigb  <= n1_sigb;
            end
            if (s1_valid & s2_ready) begin
                sign_m  <= s1_sign;
                scale_m <= n2_scale;
                mts_m   <= n2_mts;
                zero_m  <= s1_zero;
                nar_m   <= s1_nar;
            end
        end
    end
endmodule
